// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - requester and result handshake bundle for the shared logic unit
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic [1:0]       r0_op;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic [1:0]       r1_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_id;
  logic             out_zero;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    output r0_ready,
    input  r1_valid, r1_a, r1_b, r1_op,
    output r1_ready,
    output out_valid, out_y, out_id, out_zero,
    input  out_ready
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    input  r0_ready,
    output r1_valid, r1_a, r1_b, r1_op,
    input  r1_ready,
    input  out_valid, out_y, out_id, out_zero,
    output out_ready
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin shared AND/OR/XOR/NOR unit with held valid/ready result
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count0,
  output logic [CNT_W-1:0]     op_count1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] result;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_id_q;
  logic             out_zero_q;

  // On contention the requester that did not win last time gets the unit.
  always_comb begin
    grant0 = bus.r0_valid & (~bus.r1_valid | last_grant);
    grant1 = bus.r1_valid & (~bus.r0_valid | ~last_grant);
  end

  assign bus.r0_ready  = (state == IDLE) & grant0;
  assign bus.r1_ready  = (state == IDLE) & grant1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_zero  = out_zero_q;
  assign busy          = (state != IDLE);

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~(a_q | b_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_id_q    <= 1'b0;
      out_zero_q  <= 1'b0;
      op_count0   <= '0;
      op_count1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            a_q   <= bus.r0_a;
            b_q   <= bus.r0_b;
            op_q  <= bus.r0_op;
            id_q  <= 1'b0;
            state <= EXEC;
          end else if (grant1) begin
            a_q   <= bus.r1_a;
            b_q   <= bus.r1_b;
            op_q  <= bus.r1_op;
            id_q  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          out_y_q     <= result;
          out_zero_q  <= (result == '0);
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // The operation only counts once the consumer has taken the result.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            last_grant  <= out_id_q;
            if (out_id_q) op_count1 <= op_count1 + CNT_ONE;
            else          op_count0 <= op_count0 + CNT_ONE;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized transaction-model bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] op_count0;
  logic [CNT_W-1:0] op_count1;

  logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .op_count0 (op_count0),
    .op_count1 (op_count1)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level reference: one operation in flight, result visible one cycle after accept.
  bit               m_inflight;
  bit               m_vis;
  logic [31:0]      m_y;
  bit               m_id;
  bit               m_last;
  logic [CNT_W-1:0] m_cnt0;
  logic [CNT_W-1:0] m_cnt1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] logic_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic model_reset();
    m_inflight = 0;
    m_vis      = 0;
    m_y        = '0;
    m_id       = 0;
    m_last     = 1;
    m_cnt0     = '0;
    m_cnt1     = '0;
  endtask

  task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] o0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] o1,
                      input bit ordy);
    int win;
    @(negedge clk);
    check("out_valid", bus.out_valid, m_vis);
    check("busy", busy, m_inflight);
    if (m_vis) begin
      check("out_y", bus.out_y, m_y);
      check("out_id", bus.out_id, m_id);
      check("out_zero", bus.out_zero, m_y == 0);
    end
    check("op_count0", op_count0, m_cnt0);
    check("op_count1", op_count1, m_cnt1);

    bus.r0_valid = v0; bus.r0_a = a0; bus.r0_b = b0; bus.r0_op = o0;
    bus.r1_valid = v1; bus.r1_a = a1; bus.r1_b = b1; bus.r1_op = o1;
    bus.out_ready = ordy;
    #1;
    win = -1;
    if (!m_inflight) begin
      if (v0 && v1) win = m_last ? 0 : 1;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    check("r0_ready", bus.r0_ready, win == 0);
    check("r1_ready", bus.r1_ready, win == 1);
    check("ready_excl", bus.r0_ready & bus.r1_ready, 0);

    @(posedge clk);
    if (!m_inflight) begin
      if (win == 0) begin m_inflight = 1; m_y = logic_op(o0, a0, b0); m_id = 0; end
      if (win == 1) begin m_inflight = 1; m_y = logic_op(o1, a1, b1); m_id = 1; end
    end else if (!m_vis) begin
      m_vis = 1;
    end else if (ordy) begin
      m_inflight = 0;
      m_vis      = 0;
      m_last     = m_id;
      if (m_id) m_cnt1 = m_cnt1 + 1'b1;
      else      m_cnt0 = m_cnt0 + 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, '0, '0, 2'b00, 0, '0, '0, 2'b00, ordy);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.r0_valid = 0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_op = 2'b00;
    bus.r1_valid = 0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_op = 2'b00;
    bus.out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt0", op_count0, 0);
    rst = 1'b0;

    step(1, 32'hFFFF_FFFC, 32'h0000_0003, 2'b01, 0, '0, '0, 2'b00, 1);
    idle(3, 1);
    check("t1_cnt0", op_count0, 1);

    for (int op = 0; op < 4; op++) begin
      step(0, '0, '0, 2'b00, 1, 32'h0000_000F, 32'h0000_00FF, op[1:0], 1);
      idle(2, 1);
    end
    idle(1, 1);
    check("t2_cnt1", op_count1, 4);

    for (int i = 0; i < 18; i++)
      step(1, $urandom, $urandom, 2'($urandom), 1, $urandom, $urandom, 2'($urandom), 1);
    idle(2, 1);

    step(0, '0, '0, 2'b00, 1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b10, 0);
    for (int i = 0; i < 7; i++) step(1, $urandom, $urandom, 2'b00, 1, $urandom, $urandom, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 2'b00, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b01, 1);
    idle(2, 1);

    step(1, 32'h0, 32'h0, 2'b00, 0, '0, '0, 2'b00, 1);
    idle(3, 1);
    step(1, 32'h0, 32'h0, 2'b11, 0, '0, '0, 2'b00, 1);
    idle(3, 1);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 2) != 0, rand_operand(), rand_operand(), 2'($urandom),
           $urandom_range(0, 2) != 0, rand_operand(), rand_operand(), 2'($urandom),
           $urandom_range(0, 3) != 0);
    idle(4, 1);

    // Asynchronous reset between the accept edge and the compute edge.
    step(0, '0, '0, 2'b00, 1, 32'hDEAD_BEEF, 32'h0000_FFFF, 2'b00, 1);
    #2;
    rst = 1'b1;
    bus.r0_valid = 0;
    bus.r1_valid = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt0", op_count0, 0);
    check("arst_cnt1", op_count1, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 32'h0000_00F0, 32'h0000_000F, 2'b01, 1, 32'h1, 32'h1, 2'b00, 1);
    idle(3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
